rnf_txreq: RTL

Transmit side of the CHI REQ channel inside the RN-F: takes request flits from the RN-F request generator, buffers them, and drives them onto TXREQFLIT under link-layer credit (L-credit) flow control toward the HN-F receiver. It owns the L-credit counter and the FLITPEND-before-FLITV timing. During link deactivation it returns every held credit as an LCrdReturn flit.

---
 rtl/rnf_txreq.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/rnf_txreq.sv
// rnf_txreq: CHI REQ-channel transmitter of the RN-F.
//   Buffers request flits from the request generator in a small FIFO and
//   drives them onto TXREQFLIT under L-credit flow control. FLITPEND is
//   registered so that FLITV only rises one cycle after PEND was high.
//   During link deactivation every held credit is handed back as an
//   LCrdReturn flit (Opcode 6'h00, all fields zero, i.e. an all-zero flit).
//
// Ports
//   clock, reset_n       : clock, asynchronous active-low reset
//   txreq_entry[_valid]  : request flit in (FLIT_W bits), valid
//   txreq_entry_ready    : flit accepted this cycle
//   link_active_req      : 1 = run link, 0 = deactivate
//   link_stopped         : STOP state with no credits held
//   TXREQFLIT/V/PEND     : flit to HN-F, valid, pending (next-cycle) hint
//   TXREQLCRDV           : one L-credit granted by the receiver
//
// OVF_ERR_EN enables the run-time error on a credit grant beyond CRD_MAX.
module rnf_txreq #(
  parameter int unsigned CRD_MAX    = 15,
  parameter int unsigned QDEPTH     = 2,
  parameter int unsigned FLIT_W     = 64,
  parameter bit          OVF_ERR_EN = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [FLIT_W-1:0] txreq_entry,
  input  logic              txreq_entry_valid,
  output logic              txreq_entry_ready,
  input  logic              link_active_req,
  output logic              link_stopped,
  output logic [FLIT_W-1:0] TXREQFLIT,
  output logic              TXREQFLITV,
  output logic              TXREQFLITPEND,
  input  logic              TXREQLCRDV
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = $clog2(CRD_MAX + 1);

  localparam logic [PW:0]   DEPTH_L   = QDEPTH[PW:0];
  localparam logic [CW-1:0] CRD_MAX_L = CRD_MAX[CW-1:0];

  localparam logic [1:0] ST_STOP   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_RETURN = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     crd_cnt_q, crd_cnt_d;
  logic              pend_q;
  logic [FLIT_W-1:0] mem_q [QDEPTH];
  logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [PW:0]       cnt_q, cnt_d;

  logic empty, full, push, pop, crd_nz, crd_ovf, flitv, pend;

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == DEPTH_L);
  assign crd_nz = (crd_cnt_q != '0);

  assign txreq_entry_ready = (state_q == ST_RUN) & link_active_req & ~full;
  assign push = txreq_entry_valid & txreq_entry_ready;

  // Only credits already registered count; a grant this cycle is usable next.
  always_comb begin
    flitv = 1'b0;
    case (state_q)
      ST_RUN:    flitv = pend_q & crd_nz & ~empty;
      ST_RETURN: flitv = pend_q & crd_nz;
      default:   flitv = 1'b0;
    endcase
  end

  assign pop = flitv & (state_q == ST_RUN);

  assign pend = ((state_q == ST_RUN) & (~empty | txreq_entry_valid))
              | (state_q == ST_RETURN)
              | ((state_q == ST_STOP) & ~link_active_req & crd_nz);

  assign crd_ovf = TXREQLCRDV & ~flitv & (crd_cnt_q == CRD_MAX_L);

  always_comb begin
    crd_cnt_d = crd_cnt_q;
    case ({TXREQLCRDV, flitv})
      2'b10:   crd_cnt_d = crd_ovf ? crd_cnt_q : crd_cnt_q + CW'(1);
      2'b01:   crd_cnt_d = crd_cnt_q - CW'(1);
      default: crd_cnt_d = crd_cnt_q;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOP: begin
        if (link_active_req)  state_d = ST_RUN;
        else if (crd_nz)      state_d = ST_RETURN;
      end
      // Deactivation waits for the FIFO to drain; pushes are already blocked.
      ST_RUN: begin
        if (!link_active_req && empty) state_d = ST_RETURN;
      end
      ST_RETURN: begin
        if (link_active_req)        state_d = ST_RUN;
        else if (crd_cnt_d == '0)   state_d = ST_STOP;
      end
      default: state_d = ST_STOP;
    endcase
  end

  assign TXREQFLITV    = flitv;
  assign TXREQFLITPEND = pend;
  assign TXREQFLIT     = (state_q == ST_RUN) ? mem_q[rd_ptr_q] : '0;
  assign link_stopped  = (state_q == ST_STOP) & ~crd_nz;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_STOP;
      crd_cnt_q <= '0;
      pend_q    <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      crd_cnt_q <= crd_cnt_d;
      pend_q    <= pend;
      cnt_q     <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Data storage needs no reset: occupancy is tracked by cnt_q.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= txreq_entry;
  end

  always_ff @(posedge clock) begin
    if (reset_n && OVF_ERR_EN) begin
      assert (!crd_ovf)
        else $error("rnf_txreq: L-credit grant beyond CRD_MAX");
    end
  end

endmodule
